// File: rtl/rx_bit_ctrl.sv
// rtl/rx_bit_ctrl.sv - UART receive bit-timing controller
//
// Synchronises the raw serial line, detects and validates the start bit,
// then issues one shift_strobe per bit period (mid-bit) to a downstream
// 9-bit shift register (8 data bits + stop bit).  After the ninth strobe
// the stop bit returned by that register decides between a buffer load
// and a sticky framing error.
//
// Ports:
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   serial_in     in   raw asynchronous serial line, idle high
//   stop_bit      in   bit 8 of the downstream shift register
//   shift_strobe  out  one-cycle pulse, downstream shifts serial_in
//   sbc_clear     out  one-cycle pulse at start-bit detection
//   load_buffer   out  one-cycle pulse, valid frame received
//   framing_error out  sticky bad-stop-bit flag, cleared by next sbc_clear
//   rx_busy       out  high whenever the controller is not idle

module rx_bit_ctrl #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic n_rst,
   input  logic serial_in,
   input  logic stop_bit,
   output logic shift_strobe,
   output logic sbc_clear,
   output logic load_buffer,
   output logic framing_error,
   output logic rx_busy
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [3:0]       LAST_BIT_IDX  = 4'd8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      RECV     = 3'd2,
      STOP_CHK = 3'd3,
      LOAD     = 3'd4
   } state_t;

   state_t           state;
   logic             sync_meta;
   logic             s;
   logic             s_prev;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bits;

   logic start_edge;
   logic half_done;
   logic bit_done;

   assign start_edge = s_prev & ~s;
   assign half_done  = (cnt == CNT_HALF_LAST);
   assign bit_done   = (cnt == CNT_BIT_LAST);

   // Strobe and clear live in disjoint states, so they can never coincide.
   assign shift_strobe = (state == RECV) && bit_done;
   assign sbc_clear    = (state == IDLE) && start_edge;
   assign load_buffer  = (state == LOAD);
   assign rx_busy      = (state != IDLE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_meta     <= 1'b1;
         s             <= 1'b1;
         s_prev        <= 1'b1;
         state         <= IDLE;
         cnt           <= '0;
         bits          <= '0;
         framing_error <= 1'b0;
      end else begin
         sync_meta <= serial_in;
         s         <= sync_meta;
         s_prev    <= s;

         case (state)
            IDLE: begin
               cnt <= '0;
               // Only a fresh 1->0 transition starts a frame; a line that is
               // already low when we come back to idle is ignored.
               if (start_edge) begin
                  state         <= START;
                  framing_error <= 1'b0;
               end
            end

            START: begin
               if (half_done) begin
                  cnt <= '0;
                  if (!s) begin
                     state <= RECV;
                     bits  <= '0;
                  end else begin
                     // Line went back high before mid start bit: glitch.
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            RECV: begin
               if (bit_done) begin
                  cnt  <= '0;
                  bits <= bits + 4'd1;
                  // This strobe is the ninth (stop bit) one.
                  if (bits == LAST_BIT_IDX) begin
                     state <= STOP_CHK;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            STOP_CHK: begin
               cnt <= '0;
               if (stop_bit) begin
                  state <= LOAD;
               end else begin
                  state         <= IDLE;
                  framing_error <= 1'b1;
               end
            end

            LOAD: begin
               cnt   <= '0;
               state <= IDLE;
            end

            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
